// File: rtl/vp_voice_pkg.sv
`default_nettype none
// ============================================================================
// Module : vp_voice_pkg
// Brief  : Shared types and bank-select addresses for The Voice command path.
// Rev    : 1.0
// ============================================================================
package vp_voice_pkg;

    typedef logic [1:0] voice_bank_t;

    typedef struct packed {
        logic [5:0]  allo;
        voice_bank_t bank;
    } voice_cmd_t;

    localparam logic [7:0] VOICE_BANK_INT = 8'hE4;
    localparam logic [7:0] VOICE_BANK_E8  = 8'hE8;
    localparam logic [7:0] VOICE_BANK_E9  = 8'hE9;
    localparam logic [7:0] VOICE_BANK_EA  = 8'hEA;

    localparam int VOICE_CMD_W = $bits(voice_cmd_t);

    // Returns {hit, bank}; hit is set only for the four bank-select addresses.
    function automatic logic [2:0] decode_bank(input logic [7:0] addr);
        logic [2:0] res;
        res = 3'b000;
        case (addr)
            VOICE_BANK_INT: res = {1'b1, 2'd0};
            VOICE_BANK_E8:  res = {1'b1, 2'd1};
            VOICE_BANK_E9:  res = {1'b1, 2'd2};
            VOICE_BANK_EA:  res = {1'b1, 2'd3};
            default:        res = 3'b000;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vp_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : vp_sync_fifo
// Brief  : Generic single-clock FIFO, async reset, sync clear, pop-before-push.
// Rev    : 1.0
// ============================================================================
module vp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty & ~clr;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok) & ~clr;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vp_voice_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module : vp_voice_cmd_rx
// Brief  : Decodes console writes into Voice bank selects and queued allophones.
// Rev    : 1.0
// ============================================================================
module vp_voice_cmd_rx
    import vp_voice_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       soft_clr_i,
    input  logic       wr_n_i,
    input  logic [7:0] addr_i,
    output logic       busy_o,
    output logic       cmd_valid_o,
    output logic [5:0] cmd_allo_o,
    output logic [1:0] cmd_bank_o,
    input  logic       cmd_ready_i,
    output logic [1:0] bank_o,
    output logic       overflow_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_n_q;
    logic          stb;
    logic [2:0]    bank_dec;
    logic          bank_wr;
    logic          cmd_wr;
    logic          pop;
    voice_bank_t   bank_q;
    logic          overflow_q;
    voice_cmd_t    push_cmd;
    voice_cmd_t    head_cmd;
    voice_cmd_t    hold_cmd;
    voice_cmd_t    out_cmd;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign stb      = wr_n_q & ~wr_n_i;
    assign bank_dec = decode_bank(addr_i);
    assign bank_wr  = stb & addr_i[7] & bank_dec[2] & ~soft_clr_i;
    assign cmd_wr   = stb & addr_i[7] & ~bank_dec[2] & ~soft_clr_i;
    assign pop      = cmd_valid_o & cmd_ready_i & ~soft_clr_i;

    assign push_cmd.allo = addr_i[5:0];
    assign push_cmd.bank = bank_q;

    vp_sync_fifo #(
        .WIDTH (VOICE_CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (soft_clr_i),
        .push    (cmd_wr),
        .pop     (pop),
        .wdata   (push_cmd),
        .rdata   (head_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_n_q     <= 1'b1;
            bank_q     <= '0;
            overflow_q <= 1'b0;
            hold_cmd   <= '0;
        end else begin
            // Edge detector keeps tracking through a clear so no stale strobe appears.
            wr_n_q <= wr_n_i;
            if (soft_clr_i) begin
                bank_q     <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (bank_wr) begin
                    bank_q <= bank_dec[1:0];
                end
                if (cmd_wr & fifo_full & ~pop) begin
                    overflow_q <= 1'b1;
                end
            end
            if (pop) begin
                hold_cmd <= head_cmd;
            end
        end
    end

    // Once drained, the outputs keep showing the last command the synth took.
    assign out_cmd     = fifo_empty ? hold_cmd : head_cmd;
    assign cmd_valid_o = ~fifo_empty;
    assign cmd_allo_o  = out_cmd.allo;
    assign cmd_bank_o  = out_cmd.bank;
    assign busy_o      = (fifo_count == CW'(DEPTH));
    assign bank_o      = bank_q;
    assign overflow_o  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_vp_voice_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_vp_voice_cmd_rx
// Brief  : Self-checking bench: vector table plus queue scoreboard of commands.
// Rev    : 1.0
// ============================================================================
module tb_vp_voice_cmd_rx;
    import vp_voice_pkg::*;

    localparam int DEPTH = 2;

    logic       clk_sys;
    logic       reset;
    logic       soft_clr_i;
    logic       wr_n_i;
    logic [7:0] addr_i;
    logic       busy_o;
    logic       cmd_valid_o;
    logic [5:0] cmd_allo_o;
    logic [1:0] cmd_bank_o;
    logic       cmd_ready_i;
    logic [1:0] bank_o;
    logic       overflow_o;

    vp_voice_cmd_rx #(.DEPTH(DEPTH)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .soft_clr_i  (soft_clr_i),
        .wr_n_i      (wr_n_i),
        .addr_i      (addr_i),
        .busy_o      (busy_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_allo_o  (cmd_allo_o),
        .cmd_bank_o  (cmd_bank_o),
        .cmd_ready_i (cmd_ready_i),
        .bank_o      (bank_o),
        .overflow_o  (overflow_o)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0] addr;
        logic       ready;
        logic [1:0] bank;
        logic       valid;
        logic [5:0] allo;
        logic [1:0] cbank;
        logic       busy;
        logic       ovf;
    } vec_t;

    vec_t tbl [7];

    int checks   = 0;
    int failures = 0;

    // Scoreboard: commands expected to come out of the DUT, oldest first.
    voice_cmd_t  sb_q [$];
    voice_bank_t m_bank;
    logic        m_ovf;
    logic        m_wrn_q;
    voice_cmd_t  m_last;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_bank  = '0;
        m_ovf   = 1'b0;
        m_wrn_q = 1'b1;
        m_last  = '0;
    endtask

    task automatic check_outputs();
        chk("valid", int'(cmd_valid_o), int'(sb_q.size() != 0));
        chk("busy", int'(busy_o), int'(sb_q.size() == DEPTH));
        chk("bank", int'(bank_o), int'(m_bank));
        chk("overflow", int'(overflow_o), int'(m_ovf));
        if (sb_q.size() == 0) begin
            chk("hold_allo", int'(cmd_allo_o), int'(m_last.allo));
            chk("hold_bank", int'(cmd_bank_o), int'(m_last.bank));
        end else begin
            chk("head_allo", int'(cmd_allo_o), int'(sb_q[0].allo));
            chk("head_bank", int'(cmd_bank_o), int'(sb_q[0].bank));
        end
    endtask

    // Called at a falling edge: check, drive, advance model to the next rising edge.
    task automatic cycle(input logic wn, input logic [7:0] a, input logic rdy, input logic clr);
        logic       stb;
        logic [2:0] dec;
        voice_cmd_t c;
        check_outputs();
        wr_n_i      = wn;
        addr_i      = a;
        cmd_ready_i = rdy;
        soft_clr_i  = clr;
        stb     = m_wrn_q & ~wn;
        m_wrn_q = wn;
        if (clr) begin
            sb_q.delete();
            m_bank = '0;
            m_ovf  = 1'b0;
        end else begin
            if (rdy && sb_q.size() != 0) begin
                chk("pop_allo", int'(cmd_allo_o), int'(sb_q[0].allo));
                chk("pop_bank", int'(cmd_bank_o), int'(sb_q[0].bank));
                m_last = sb_q.pop_front();
            end
            if (stb && a[7]) begin
                dec = decode_bank(a);
                if (dec[2]) begin
                    m_bank = dec[1:0];
                end else if (sb_q.size() < DEPTH) begin
                    c.allo = a[5:0];
                    c.bank = m_bank;
                    sb_q.push_back(c);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(negedge clk_sys);
    endtask

    task automatic do_write(input logic [7:0] a, input logic rdy);
        cycle(1'b0, a, rdy, 1'b0);
        cycle(1'b1, a, 1'b0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{8'hE9, 1'b0, 2'd2, 1'b0, 6'h00, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 1'b0, 2'd2, 1'b1, 6'h25, 2'd2, 1'b0, 1'b0};
        tbl[2] = '{8'hE4, 1'b0, 2'd0, 1'b1, 6'h25, 2'd2, 1'b0, 1'b0};
        tbl[3] = '{8'h81, 1'b0, 2'd0, 1'b1, 6'h25, 2'd2, 1'b1, 1'b0};
        tbl[4] = '{8'h82, 1'b0, 2'd0, 1'b1, 6'h25, 2'd2, 1'b1, 1'b1};
        tbl[5] = '{8'h84, 1'b1, 2'd0, 1'b1, 6'h01, 2'd0, 1'b1, 1'b1};
        tbl[6] = '{8'h7F, 1'b0, 2'd0, 1'b1, 6'h01, 2'd0, 1'b1, 1'b1};

        reset       = 1'b1;
        soft_clr_i  = 1'b0;
        wr_n_i      = 1'b1;
        addr_i      = 8'h00;
        cmd_ready_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);

        chk("reset_busy", int'(busy_o), 0);
        chk("reset_valid", int'(cmd_valid_o), 0);
        chk("reset_allo", int'(cmd_allo_o), 0);
        chk("reset_ovf", int'(overflow_o), 0);
        cycle(1'b1, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            do_write(tbl[i].addr, tbl[i].ready);
            chk($sformatf("tbl%0d_bank", i), int'(bank_o), int'(tbl[i].bank));
            chk($sformatf("tbl%0d_valid", i), int'(cmd_valid_o), int'(tbl[i].valid));
            chk($sformatf("tbl%0d_allo", i), int'(cmd_allo_o), int'(tbl[i].allo));
            chk($sformatf("tbl%0d_cbank", i), int'(cmd_bank_o), int'(tbl[i].cbank));
            chk($sformatf("tbl%0d_busy", i), int'(busy_o), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_ovf", i), int'(overflow_o), int'(tbl[i].ovf));
        end

        repeat (3) cycle(1'b1, 8'h00, 1'b1, 1'b0);
        chk("drain_valid", int'(cmd_valid_o), 0);
        chk("drain_hold", int'(cmd_allo_o), 6'h04);

        // Write strobe held low for many cycles yields a single entry.
        repeat (20) cycle(1'b0, 8'h90, 1'b0, 1'b0);
        cycle(1'b1, 8'h90, 1'b0, 1'b0);
        chk("held_valid", int'(cmd_valid_o), 1);
        chk("held_allo", int'(cmd_allo_o), 6'h10);
        chk("held_busy", int'(busy_o), 0);
        do_write(8'h7F, 1'b0);
        chk("low_addr_busy", int'(busy_o), 0);

        do_write(8'hE8, 1'b0);
        do_write(8'h81, 1'b0);
        chk("pre_clr_busy", int'(busy_o), 1);
        cycle(1'b0, 8'h83, 1'b0, 1'b1);
        chk("clr_valid", int'(cmd_valid_o), 0);
        chk("clr_busy", int'(busy_o), 0);
        chk("clr_bank", int'(bank_o), 0);
        chk("clr_ovf", int'(overflow_o), 0);
        cycle(1'b0, 8'h83, 1'b0, 1'b0);
        cycle(1'b1, 8'h83, 1'b0, 1'b0);
        chk("post_clr_valid", int'(cmd_valid_o), 0);

        do_write(8'hA0, 1'b0);
        #2 reset = 1'b1;
        model_reset();
        @(negedge clk_sys);
        #2 reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_mid_valid", int'(cmd_valid_o), 0);
        chk("rst_mid_allo", int'(cmd_allo_o), 0);
        do_write(8'hC1, 1'b0);
        chk("post_rst_allo", int'(cmd_allo_o), 6'h01);

        for (int i = 0; i < 200; i++) begin
            logic [7:0] a;
            case ($urandom_range(0, 5))
                0:       a = VOICE_BANK_E9;
                1:       a = VOICE_BANK_EA;
                default: a = 8'($urandom_range(0, 255));
            endcase
            cycle(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 31) == 0));
        end
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
